sram_ctl: RTL and testbench
===========================

// Module: sram_ctl
// PURPOSE
//   Pipelined Wishbone B4 peripheral driving an external asynchronous SRAM; parametrised replacement for the fixed-timing RAM port.
//   Wait states come from SRAM ns timings and WB_CLOCK_MHZ. A 1-entry request buffer accepts back-to-back strobes; bus turnaround is inserted only on read->write.
// PARAMETERS
//   WB_CLOCK_MHZ  64   wb_clock_i frequency; sets ns->cycle conversion
//   DATA_WIDTH    8    SRAM/Wishbone data width
//   ADDR_WIDTH    17   SRAM/Wishbone address width
//   T_AA_NS       10   read access time (addr/OE -> DOUT valid)
//   T_WP_NS       10   minimum WE pulse width
//   T_HZ_NS       4    OE deassert -> SRAM DOUT high-Z
// PORTS
//   wb_clock_i   in   1    single clock; all logic on rising edge
//   wb_reset_i   in   1    synchronous, active-high reset
//   wb_addr_i    in   AW   request address
//   wb_data_i    in   DW   write data
//   wb_data_o    out  DW   read data, valid while wb_ack_o=1
//   wb_we_i      in   1    1=write, 0=read
//   wb_cycle_i   in   1    bus cycle active
//   wb_strobe_i  in   1    request valid; accepted when cyc&stb&!stall
//   wb_stall_o   out  1    1 = request buffer full
//   wb_ack_o     out  1    one-cycle pulse per accepted request, in order
//   ram_oe_o     out  1    SRAM output enable (active-high here)
//   ram_we_o     out  1    SRAM write enable (active-high here)
//   ram_addr_o   out  AW   SRAM address
//   ram_data_i   in   DW   SRAM data in
//   ram_data_o   out  DW   SRAM data out
//   ram_data_oe  out  1    FPGA drives data bus
// BEHAVIOUR
//   - Cycle counts: CYC(t) = max(1, ceil(t*WB_CLOCK_MHZ/1000)). RD_CYC = CYC(T_AA_NS)+1 (one sample margin),
//     WR_CYC = CYC(T_WP_NS), HZ_CYC = CYC(T_HZ_NS). At defaults: RD=2, WR=1, HZ=1.
//   - Reset (and at power-up): state IDLE, buffer empty; ram_oe_o, ram_we_o, ram_data_oe, wb_ack_o, wb_stall_o = 0;
//     wb_data_o, ram_addr_o, ram_data_o = 0. Reset mid-access drops oe/we/data_oe at that edge; no ack is issued.
//   - FSM: IDLE, READ, WSETUP, WRITE, TURN.
//     IDLE: next request (buffer head, else live bus request) loads ram_addr_o/ram_data_o.
//       Read -> READ, ram_oe_o=1. Write -> WSETUP, ram_data_oe=1 (or TURN first, see below).
//     READ: count RD_CYC cycles with oe held; final edge samples ram_data_i into wb_data_o, wb_ack_o=1.
//       With another read queued, ram_oe_o stays 1, address updates, READ restarts (no idle gap).
//     WSETUP: one cycle of address/data setup; then ram_we_o=1 -> WRITE.
//     WRITE: hold ram_we_o for WR_CYC cycles. On the final edge, ram_we_o and ram_data_oe drop together
//       (0 ns hold) and wb_ack_o=1. A read queued behind it goes directly to READ.
//     TURN: entered when a write follows a read. oe=0, data_oe=0 for HZ_CYC cycles, then WSETUP.
//   - Latency from acceptance edge to ack-visible, idle start: read RD_CYC cycles; write WR_CYC+1.
//   - Buffering: one request may be in flight and one held in the buffer. wb_stall_o=1 exactly while the buffer is full.
//     A request accepted on the same edge the in-flight access completes goes straight in flight.
//   - wb_cycle_i low while busy: the in-flight SRAM access completes (WE pulse never truncated), but its ack is suppressed.
//     The buffered request is discarded.
//   - wb_ack_o is never asserted for two requests in the same cycle. Ack order = acceptance order.
// STRUCTURE
//   - Package sram_pkg: state_t enum; function cycles_for_ns(ns, mhz); request struct {addr, data, we}.
//   - Sub-module sram_req_buf: 1-entry skid buffer (push/pop/full/head), producing wb_stall_o.
//   - A single down-counter, width $clog2(max(RD,WR,HZ)+1), is shared by READ, WRITE and TURN.
// TESTING (SRAM behavioural model with T_AA/T_HZ delays and X on violations; defaults unless noted)
//   1. Write 0x1_2345<=0xA5, then read it back -> WE high 1 cycle, data_oe spans WSETUP+WRITE; ack 2 cycles after accept;
//      read acks 0xA5 2 cycles after accept.
//   2. Four back-to-back reads, stb held high -> oe never drops between them; acks every 2 cycles; data in order; stall toggles.
//   3. Read then write on consecutive cycles -> exactly 1 TURN cycle with oe=0 and data_oe=0 before data_oe rises; no bus contention.
//   4. WB_CLOCK_MHZ=100 -> RD=2, WR=1, HZ=1. WB_CLOCK_MHZ=200 -> RD=3, WR=2, HZ=1. Pulse widths measured >= spec.
//   5. Drop cyc during a write with a read buffered -> write completes with full WE pulse; no acks; read never reaches SRAM.
//   6. Assert reset during READ -> next edge: oe/we/data_oe/ack/stall=0, FSM in IDLE; next request behaves as from power-up.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the asynchronous SRAM Wishbone controller.
package sram_pkg;

   // Controller states: idle, read access, write setup, WE pulse, read->write turnaround
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WSETUP,
      ST_WRITE,
      ST_TURN
   } state_t;

   // Whole clock cycles needed to cover t_ns at clock_mhz, never less than one
   function automatic int cycles_for_ns(input int t_ns, input int clock_mhz);
      int c;
      c = (t_ns * clock_mhz + 999) / 1000;
      return (c < 1) ? 1 : c;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sram_req_buf.sv
// One-entry skid buffer holding the request that arrives while an access is in flight.
module sram_req_buf #(
   parameter type req_t = logic
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_flush,
   input  logic i_push,
   input  logic i_pop,
   input  req_t i_req,
   output logic o_full,
   output req_t o_head
);

   logic r_full;
   req_t r_head;

   // Occupancy flag: flush beats push beats pop
   // NOTE: registers take <= so every always_ff reads pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full <= 1'b0;
      end else if (i_flush) begin
         r_full <= 1'b0;
      end else if (i_push) begin
         r_full <= 1'b1;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   // Payload capture on push
   // NOTE: the payload has no reset; it is only ever looked at while r_full is set.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_head <= i_req;
      end
   end

   assign o_full = r_full;
   assign o_head = r_head;

endmodule

// File: rtl/sram_ctl.sv
// Pipelined Wishbone peripheral driving an asynchronous SRAM with ns-derived wait states.
module sram_ctl
   import sram_pkg::*;
#(
   parameter int WB_CLOCK_MHZ = 64,
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 17,
   parameter int T_AA_NS      = 10,
   parameter int T_WP_NS      = 10,
   parameter int T_HZ_NS      = 4
) (
   input  logic                  wb_clock_i,
   input  logic                  wb_reset_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   input  logic                  wb_we_i,
   input  logic                  wb_cycle_i,
   input  logic                  wb_strobe_i,
   output logic                  wb_stall_o,
   output logic                  wb_ack_o,
   output logic                  ram_oe_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_data_i,
   output logic [DATA_WIDTH-1:0] ram_data_o,
   output logic                  ram_data_oe
);

   // Read gets one extra cycle so the sample edge lands after t_AA with margin
   localparam int RD_CYC  = cycles_for_ns(T_AA_NS, WB_CLOCK_MHZ) + 1;
   localparam int WR_CYC  = cycles_for_ns(T_WP_NS, WB_CLOCK_MHZ);
   localparam int HZ_CYC  = cycles_for_ns(T_HZ_NS, WB_CLOCK_MHZ);
   localparam int CNT_W   = $clog2(max3(RD_CYC, WR_CYC, HZ_CYC) + 1);

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);
   localparam logic [CNT_W-1:0] HZ_LOAD = CNT_W'(HZ_CYC - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic                  we;
   } req_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_abort;
   logic                  r_oe;
   logic                  r_we;
   logic                  r_doe;
   logic                  r_ack;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;

   req_t w_live;
   req_t w_head;
   req_t w_next;
   logic w_full;
   logic w_accept;
   logic w_have_req;
   logic w_cnt_zero;
   logic w_final;
   logic w_take;
   logic w_push;
   logic w_pop;
   logic w_flush;

   assign w_live     = '{addr: wb_addr_i, data: wb_data_i, we: wb_we_i};
   assign w_accept   = wb_cycle_i & wb_strobe_i & ~w_full;
   // A buffered request outranks the live bus; both vanish when the cycle is dropped
   assign w_have_req = (w_full & wb_cycle_i) | w_accept;
   assign w_next     = w_full ? w_head : w_live;
   assign w_cnt_zero = (r_cnt == '0);
   assign w_final    = ((r_state == ST_READ) || (r_state == ST_WRITE)) && w_cnt_zero;
   // Controller consumes a request only from IDLE or on the last edge of an access
   assign w_take     = w_have_req && ((r_state == ST_IDLE) || w_final);
   assign w_push     = w_accept & ~w_take;
   assign w_pop      = w_take & w_full;
   assign w_flush    = ~wb_cycle_i;

   sram_req_buf #(
      .req_t(req_t)
   ) u_req_buf (
      .i_clk  (wb_clock_i),
      .i_rst  (wb_reset_i),
      .i_flush(w_flush),
      .i_push (w_push),
      .i_pop  (w_pop),
      .i_req  (w_live),
      .o_full (w_full),
      .o_head (w_head)
   );

   // Access sequencer: all SRAM strobes and the ack come straight from registers
   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_abort <= 1'b0;
         r_oe    <= 1'b0;
         r_we    <= 1'b0;
         r_doe   <= 1'b0;
         r_ack   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_ack <= 1'b0;
         // Remember a dropped cycle so the running access finishes without an ack
         if (!wb_cycle_i && (r_state != ST_IDLE)) begin
            r_abort <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               // Counter keeps timing the high-Z window left over from a finished read
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end
               if (w_have_req) begin
                  r_addr  <= w_next.addr;
                  r_wdata <= w_next.data;
                  if (!w_next.we) begin
                     r_state <= ST_READ;
                     r_oe    <= 1'b1;
                     r_cnt   <= RD_LOAD;
                  end else if (!w_cnt_zero) begin
                     r_state <= ST_TURN;
                     r_cnt   <= r_cnt - 1'b1;
                  end else begin
                     r_state <= ST_WSETUP;
                     r_doe   <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_rdata <= ram_data_i;
                  r_ack   <= wb_cycle_i & ~r_abort;
                  r_abort <= 1'b0;
                  if (w_have_req) begin
                     r_addr  <= w_next.addr;
                     r_wdata <= w_next.data;
                     if (!w_next.we) begin
                        r_cnt <= RD_LOAD;
                     end else begin
                        r_state <= ST_TURN;
                        r_oe    <= 1'b0;
                        r_cnt   <= HZ_LOAD;
                     end
                  end else begin
                     r_state <= ST_IDLE;
                     r_oe    <= 1'b0;
                     r_cnt   <= HZ_LOAD;
                  end
               end
            end
            ST_WSETUP: begin
               r_state <= ST_WRITE;
               r_we    <= 1'b1;
               r_cnt   <= WR_LOAD;
            end
            ST_WRITE: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  // WE and the data drive release on the same edge
                  r_we    <= 1'b0;
                  r_ack   <= wb_cycle_i & ~r_abort;
                  r_abort <= 1'b0;
                  if (w_have_req) begin
                     r_addr  <= w_next.addr;
                     r_wdata <= w_next.data;
                     if (!w_next.we) begin
                        r_state <= ST_READ;
                        r_oe    <= 1'b1;
                        r_doe   <= 1'b0;
                        r_cnt   <= RD_LOAD;
                     end else begin
                        r_state <= ST_WSETUP;
                     end
                  end else begin
                     r_state <= ST_IDLE;
                     r_doe   <= 1'b0;
                  end
               end
            end
            ST_TURN: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_state <= ST_WSETUP;
                  r_doe   <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_oe    <= 1'b0;
               r_we    <= 1'b0;
               r_doe   <= 1'b0;
            end
         endcase
      end
   end

   assign wb_data_o   = r_rdata;
   assign wb_ack_o    = r_ack;
   assign wb_stall_o  = w_full;
   assign ram_oe_o    = r_oe;
   assign ram_we_o    = r_we;
   assign ram_addr_o  = r_addr;
   assign ram_data_o  = r_wdata;
   assign ram_data_oe = r_doe;

endmodule

// File: tb/tb_sram_ctl.sv
// Directed bench for sram_ctl with a timing-aware behavioural SRAM.
module tb_sram_ctl;
   import sram_pkg::*;

   localparam int HALF = 8;   // 16-unit clock period, close to 64 MHz in ns
   localparam int T_AA = 10;
   localparam int T_WP = 10;
   localparam int T_HZ = 4;

   logic clk = 1'b0;
   always #HALF clk = ~clk;

   logic        rst;
   logic [16:0] wb_addr;
   logic [7:0]  wb_wdat;
   logic [7:0]  wb_rdat;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_stall;
   logic        wb_ack;
   logic        ram_oe;
   logic        ram_we;
   logic [16:0] ram_addr;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic        ram_doe;

   sram_ctl u_dut (
      .wb_clock_i (clk),
      .wb_reset_i (rst),
      .wb_addr_i  (wb_addr),
      .wb_data_i  (wb_wdat),
      .wb_data_o  (wb_rdat),
      .wb_we_i    (wb_we),
      .wb_cycle_i (wb_cyc),
      .wb_strobe_i(wb_stb),
      .wb_stall_o (wb_stall),
      .wb_ack_o   (wb_ack),
      .ram_oe_o   (ram_oe),
      .ram_we_o   (ram_we),
      .ram_addr_o (ram_addr),
      .ram_data_i (ram_din),
      .ram_data_o (ram_dout),
      .ram_data_oe(ram_doe)
   );

   // Second instance at 200 MHz: RD=3, WR=2, HZ=1
   logic [16:0] d2_addr;
   logic [7:0]  d2_wdat;
   logic [7:0]  d2_rdat;
   logic        d2_we;
   logic        d2_cyc;
   logic        d2_stb;
   logic        d2_stall;
   logic        d2_ack;
   logic        d2_oe;
   logic        d2_ram_we;
   logic [16:0] d2_ram_addr;
   logic [7:0]  d2_ram_in;
   logic [7:0]  d2_ram_out;
   logic        d2_doe;

   sram_ctl #(.WB_CLOCK_MHZ(200)) u_dut200 (
      .wb_clock_i (clk),
      .wb_reset_i (rst),
      .wb_addr_i  (d2_addr),
      .wb_data_i  (d2_wdat),
      .wb_data_o  (d2_rdat),
      .wb_we_i    (d2_we),
      .wb_cycle_i (d2_cyc),
      .wb_strobe_i(d2_stb),
      .wb_stall_o (d2_stall),
      .wb_ack_o   (d2_ack),
      .ram_oe_o   (d2_oe),
      .ram_we_o   (d2_ram_we),
      .ram_addr_o (d2_ram_addr),
      .ram_data_i (d2_ram_in),
      .ram_data_o (d2_ram_out),
      .ram_data_oe(d2_doe)
   );

   // ---------------- behavioural SRAM ----------------
   logic [7:0]  mem [0:(1<<17)-1];
   realtime     t_acc = 0;
   realtime     t_we_rise = 0;
   realtime     t_oe_fall = -1000;
   realtime     we_width = 0;
   logic        we_seen = 1'b0;
   logic        contention = 1'b0;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;

   always @(ram_addr or ram_oe) t_acc = $realtime;

   // Drive read data for the coming edge: X unless t_AA has elapsed with OE up
   always @(negedge clk) begin
      if (ram_oe && !ram_doe && (($realtime + HALF - t_acc) >= T_AA))
         ram_din = mem[ram_addr];
      else
         ram_din = 'x;
   end

   always @(posedge ram_we) begin
      t_we_rise = $realtime;
      wr_addr   = ram_addr;
      wr_data   = ram_dout;
      we_seen   = 1'b1;
   end

   always @(negedge ram_we) begin
      if (we_seen) begin
         we_width = $realtime - t_we_rise;
         mem[wr_addr] = (we_width >= T_WP) ? wr_data : 'x;
      end
   end

   always @(negedge ram_oe) t_oe_fall = $realtime;

   always @(posedge ram_doe) begin
      if (ram_oe || (($realtime - t_oe_fall) < T_HZ)) contention = 1'b1;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [16:0] t2_addr [4];
   logic [7:0]  t2_data [4];

   initial begin
      logic       acc;
      int         idx;
      int         ackn;
      int         oe_drops;
      logic [9:0] stall_vec;
      int         lat;
      int         we_cyc;
      int         oe_cyc;
      int         acks;
      int         oes;

      rst = 1'b1;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdat = '0;
      d2_cyc = 1'b0; d2_stb = 1'b0; d2_we = 1'b0; d2_addr = '0; d2_wdat = '0;
      d2_ram_in = 8'h3C;
      repeat (3) tick();

      // Reset state
      check("rst_oe", ram_oe, 0);
      check("rst_we", ram_we, 0);
      check("rst_doe", ram_doe, 0);
      check("rst_ack", wb_ack, 0);
      check("rst_stall", wb_stall, 0);
      check("rst_rdata", wb_rdat, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_dout, 0);

      // Cycle conversion, including the floor of one cycle
      check("cyc_aa_64", cycles_for_ns(10, 64), 1);
      check("cyc_hz_64", cycles_for_ns(4, 64), 1);
      check("cyc_aa_100", cycles_for_ns(10, 100), 1);
      check("cyc_aa_200", cycles_for_ns(10, 200), 2);
      check("cyc_hz_200", cycles_for_ns(4, 200), 1);
      check("cyc_zero", cycles_for_ns(0, 64), 1);

      rst = 1'b0;
      tick();

      // ---- 1: write 0x12345 <= 0xA5, read it back ----
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 17'h12345; wb_wdat = 8'hA5;
      tick();
      wb_stb = 1'b0;
      check("t1_setup_doe", ram_doe, 1);
      check("t1_setup_we", ram_we, 0);
      check("t1_addr", ram_addr, 17'h12345);
      check("t1_dout", ram_dout, 8'hA5);
      tick();
      check("t1_we_high", ram_we, 1);
      check("t1_we_doe", ram_doe, 1);
      check("t1_no_early_ack", wb_ack, 0);
      tick();
      check("t1_we_low", ram_we, 0);
      check("t1_doe_low", ram_doe, 0);
      check("t1_wr_ack", wb_ack, 1);
      tick();
      check("t1_ack_pulse", wb_ack, 0);
      check("t1_mem", mem[17'h12345], 8'hA5);
      check("t1_we_width", (we_width >= T_WP), 1);

      wb_stb = 1'b1; wb_we = 1'b0;
      tick();
      wb_stb = 1'b0;
      check("t1_rd_oe", ram_oe, 1);
      check("t1_rd_ack0", wb_ack, 0);
      tick();
      check("t1_rd_ack1", wb_ack, 0);
      tick();
      check("t1_rd_ack", wb_ack, 1);
      check("t1_rd_data", wb_rdat, 8'hA5);
      check("t1_rd_oe_off", ram_oe, 0);
      tick();

      // ---- 2: four back-to-back reads, strobe held ----
      t2_addr[0] = 17'h00010; t2_data[0] = 8'h11;
      t2_addr[1] = 17'h1FFFF; t2_data[1] = 8'h22;
      t2_addr[2] = 17'h00000; t2_data[2] = 8'h33;
      t2_addr[3] = 17'h0AAAA; t2_data[3] = 8'h44;
      for (int k = 0; k < 4; k++) mem[t2_addr[k]] = t2_data[k];
      idx = 0; ackn = 0; oe_drops = 0; stall_vec = '0;
      wb_stb = 1'b1; wb_we = 1'b0; wb_addr = t2_addr[0];
      for (int n = 0; n < 10; n++) begin
         acc = wb_stb && !wb_stall;
         tick();
         if (acc) begin
            idx++;
            if (idx < 4) wb_addr = t2_addr[idx];
            else wb_stb = 1'b0;
         end
         if (wb_ack) begin
            if (ackn < 4) begin
               check("t2_data", wb_rdat, t2_data[ackn]);
               check("t2_ack_cycle", n, 2 * ackn + 2);
            end else begin
               check("t2_extra_ack", 1, 0);
            end
            ackn++;
         end
         if (n < 8 && !ram_oe) oe_drops++;
         stall_vec[n] = wb_stall;
      end
      check("t2_ack_count", ackn, 4);
      check("t2_oe_gaps", oe_drops, 0);
      check("t2_stall_pattern", stall_vec, 10'b0000101010);

      // ---- 3: read then write on consecutive cycles ----
      mem[17'h00055] = 8'h66;
      contention = 1'b0;
      wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 17'h00055;
      tick();
      wb_we = 1'b1; wb_addr = 17'h00077; wb_wdat = 8'h99;
      tick();
      wb_stb = 1'b0;
      check("t3_buffered", wb_stall, 1);
      tick();
      check("t3_rd_ack", wb_ack, 1);
      check("t3_rd_data", wb_rdat, 8'h66);
      check("t3_turn_oe", ram_oe, 0);
      check("t3_turn_doe", ram_doe, 0);
      tick();
      check("t3_setup_doe", ram_doe, 1);
      check("t3_setup_oe", ram_oe, 0);
      check("t3_setup_we", ram_we, 0);
      tick();
      check("t3_we_high", ram_we, 1);
      tick();
      check("t3_wr_ack", wb_ack, 1);
      check("t3_doe_off", ram_doe, 0);
      check("t3_contention", contention, 0);
      check("t3_mem", mem[17'h00077], 8'h99);
      tick();

      // ---- 4: 200 MHz instance timing ----
      d2_cyc = 1'b1; d2_stb = 1'b1; d2_we = 1'b1; d2_addr = 17'h00001; d2_wdat = 8'h05;
      tick();
      d2_stb = 1'b0;
      lat = 0; we_cyc = 0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (d2_ram_we) we_cyc++;
         if (d2_ack && lat == 0) lat = n;
      end
      check("t4_wr_latency", lat, 3);
      check("t4_we_cycles", we_cyc, 2);

      d2_stb = 1'b1; d2_we = 1'b0;
      tick();
      d2_stb = 1'b0;
      lat = 0;
      oe_cyc = d2_oe ? 1 : 0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (d2_oe) oe_cyc++;
         if (d2_ack && lat == 0) begin
            lat = n;
            check("t4_rd_data", d2_rdat, 8'h3C);
         end
      end
      check("t4_rd_latency", lat, 3);
      check("t4_oe_cycles", oe_cyc, 3);
      d2_cyc = 1'b0;

      // ---- 5: drop cyc during a write with a read buffered ----
      mem[17'h00100] = 8'h00;
      mem[17'h00200] = 8'h77;
      wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 17'h00100; wb_wdat = 8'h5A;
      tick();
      wb_we = 1'b0; wb_addr = 17'h00200;
      tick();
      check("t5_buffered", wb_stall, 1);
      check("t5_we_high", ram_we, 1);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      acks = 0; oes = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (wb_ack) acks++;
         if (ram_oe) oes++;
      end
      check("t5_no_acks", acks, 0);
      check("t5_no_read", oes, 0);
      check("t5_stall_clear", wb_stall, 0);
      check("t5_mem", mem[17'h00100], 8'h5A);
      check("t5_we_width", (we_width >= T_WP), 1);

      // ---- 6: reset during READ ----
      mem[17'h00300] = 8'hC3;
      mem[17'h00301] = 8'h3C;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 17'h00300;
      tick();
      wb_addr = 17'h00301;
      tick();
      check("t6_pre_stall", wb_stall, 1);
      check("t6_pre_oe", ram_oe, 1);
      rst = 1'b1; wb_stb = 1'b0;
      tick();
      check("t6_oe", ram_oe, 0);
      check("t6_we", ram_we, 0);
      check("t6_doe", ram_doe, 0);
      check("t6_ack", wb_ack, 0);
      check("t6_stall", wb_stall, 0);
      check("t6_addr", ram_addr, 0);
      rst = 1'b0;
      tick();
      check("t6_no_late_ack", wb_ack, 0);
      wb_stb = 1'b1; wb_addr = 17'h00301;
      tick();
      wb_stb = 1'b0;
      check("t6_new_oe", ram_oe, 1);
      tick();
      check("t6_new_ack0", wb_ack, 0);
      tick();
      check("t6_new_ack", wb_ack, 1);
      check("t6_new_data", wb_rdat, 8'h3C);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
